// File: rtl/morra_cinese_param.sv
// Rock-paper-scissors (morra cinese) match referee: validates each manche,
// keeps score, and ends the match on a qualified lead or on the manche limit.
module morra_cinese_param #(
  parameter int LEAD       = 2,
  parameter int MIN_MANCHE = 4,
  parameter int MAX_BASE   = 4,
  parameter int CW         = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    PRIMO,
  input  logic [1:0]    SECONDO,
  input  logic          INIZIO,
  output logic [1:0]    MANCHE,
  output logic [1:0]    PARTITA,
  output logic [CW-1:0] COUNT
);

  generate
    if (LEAD < 1 || MIN_MANCHE < 1 || MIN_MANCHE > MAX_BASE ||
        (MAX_BASE + 15) >= (2 ** CW)) begin : g_bad_params
      $error("morra_cinese_param: illegal parameter combination");
    end
  endgenerate

  typedef enum logic {
    S_IDLE,
    S_PLAY
  } state_t;

  typedef enum logic [1:0] {
    W_NONE,
    W_P1,
    W_P2
  } winner_t;

  localparam logic [1:0] MOVE_NONE    = 2'b00;
  localparam logic [1:0] MOVE_SASSO   = 2'b01;
  localparam logic [1:0] MOVE_CARTA   = 2'b10;
  localparam logic [1:0] MOVE_FORBICE = 2'b11;

  // Shared encoding for MANCHE and PARTITA (11 = tie / draw).
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_TIE  = 2'b11;

  localparam logic signed [CW:0] D_ONE    = (CW + 1)'(1);
  localparam logic signed [CW:0] D_ZERO   = '0;
  localparam logic signed [CW:0] LEAD_POS = (CW + 1)'(LEAD);
  localparam logic signed [CW:0] LEAD_NEG = -LEAD_POS;
  localparam logic [CW-1:0]      MIN_CNT  = CW'(MIN_MANCHE);
  localparam logic [CW-1:0]      MAX_RST  = CW'(MAX_BASE);

  state_t                r_state;
  logic [CW-1:0]         r_count;
  logic signed [CW:0]    r_d;
  winner_t               r_prev_winner;
  logic [1:0]            r_prev_move;
  logic [CW-1:0]         r_max;
  logic [1:0]            r_manche;
  logic [1:0]            r_partita;

  state_t                w_state;
  logic [CW-1:0]         w_count;
  logic signed [CW:0]    w_d;
  winner_t               w_prev_winner;
  logic [1:0]            w_prev_move;
  logic [CW-1:0]         w_max;
  logic [1:0]            w_manche;
  logic [1:0]            w_partita;

  logic                  w_moves_present;
  logic                  w_repeat;
  logic                  w_valid;
  logic                  w_tie;
  logic                  w_p1_beats;
  logic                  w_lead_hit;

  assign w_moves_present = (PRIMO != MOVE_NONE) && (SECONDO != MOVE_NONE);
  assign w_repeat = ((r_prev_winner == W_P1) && (PRIMO   == r_prev_move)) ||
                    ((r_prev_winner == W_P2) && (SECONDO == r_prev_move));
  assign w_valid  = w_moves_present && !w_repeat;
  assign w_tie    = (PRIMO == SECONDO);
  assign w_p1_beats = ((PRIMO == MOVE_CARTA)   && (SECONDO == MOVE_SASSO))   ||
                      ((PRIMO == MOVE_SASSO)   && (SECONDO == MOVE_FORBICE)) ||
                      ((PRIMO == MOVE_FORBICE) && (SECONDO == MOVE_CARTA));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state       = r_state;
    w_count       = r_count;
    w_d           = r_d;
    w_prev_winner = r_prev_winner;
    w_prev_move   = r_prev_move;
    w_max         = r_max;
    w_manche      = RES_NONE;
    w_partita     = RES_NONE;
    w_lead_hit    = 1'b0;

    if (INIZIO) begin
      w_state       = S_PLAY;
      w_max         = MAX_RST + CW'({PRIMO, SECONDO});
      w_count       = '0;
      w_d           = D_ZERO;
      w_prev_winner = W_NONE;
      w_prev_move   = MOVE_NONE;
    end else if (r_state == S_PLAY && w_valid) begin
      w_count = r_count + 1'b1;
      if (w_tie) begin
        w_manche      = RES_TIE;
        w_prev_winner = W_NONE;
      end else if (w_p1_beats) begin
        w_manche      = RES_P1;
        w_d           = r_d + D_ONE;
        w_prev_winner = W_P1;
        w_prev_move   = PRIMO;
      end else begin
        w_manche      = RES_P2;
        w_d           = r_d - D_ONE;
        w_prev_winner = W_P2;
        w_prev_move   = SECONDO;
      end

      // End-of-match decisions use the already-updated count and score.
      w_lead_hit = (w_count >= MIN_CNT) && ((w_d >= LEAD_POS) || (w_d <= LEAD_NEG));
      if (w_lead_hit) begin
        w_partita = (w_d > D_ZERO) ? RES_P1 : RES_P2;
        w_state   = S_IDLE;
      end else if (w_count == r_max) begin
        if (w_d > D_ZERO)      w_partita = RES_P1;
        else if (w_d < D_ZERO) w_partita = RES_P2;
        else                   w_partita = RES_TIE;
        w_state = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_d           <= D_ZERO;
      r_prev_winner <= W_NONE;
      r_prev_move   <= MOVE_NONE;
      r_max         <= MAX_RST;
      r_manche      <= RES_NONE;
      r_partita     <= RES_NONE;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      r_state       <= w_state;
      r_count       <= w_count;
      r_d           <= w_d;
      r_prev_winner <= w_prev_winner;
      r_prev_move   <= w_prev_move;
      r_max         <= w_max;
      r_manche      <= w_manche;
      r_partita     <= w_partita;
    end
  end

  assign MANCHE  = r_manche;
  assign PARTITA = r_partita;
  assign COUNT   = r_count;

endmodule

// File: tb/tb_morra_cinese_param.sv
// Self-checking bench for morra_cinese_param: table of per-cycle vectors fed
// through a scoreboard queue, plus a hand-written asynchronous-reset sequence.
module tb_morra_cinese_param;

  localparam int CW = 5;

  // Move codes and result codes, as plain ints for readable tables.
  localparam int NO = 0, SA = 1, CA = 2, FO = 3;
  localparam int RN = 0, R1 = 1, R2 = 2, RT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    PRIMO;
  logic [1:0]    SECONDO;
  logic          INIZIO;
  logic [1:0]    MANCHE;
  logic [1:0]    PARTITA;
  logic [CW-1:0] COUNT;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string         tag;
    logic          inizio;
    logic [1:0]    primo;
    logic [1:0]    secondo;
    logic [1:0]    manche;
    logic [1:0]    partita;
    logic [CW-1:0] count;
  } vec_t;

  vec_t table_q[$];
  vec_t sb_q[$];

  morra_cinese_param #(
    .LEAD(2), .MIN_MANCHE(4), .MAX_BASE(4), .CW(CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .PRIMO  (PRIMO),
    .SECONDO(SECONDO),
    .INIZIO (INIZIO),
    .MANCHE (MANCHE),
    .PARTITA(PARTITA),
    .COUNT  (COUNT)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string tag, input int ini, input int p, input int s,
                              input int m, input int pa, input int c);
    vec_t v;
    v.tag     = tag;
    v.inizio  = 1'(ini);
    v.primo   = 2'(p);
    v.secondo = 2'(s);
    v.manche  = 2'(m);
    v.partita = 2'(pa);
    v.count   = CW'(c);
    return v;
  endfunction

  task automatic check_outputs(input string name, input int m, input int pa, input int c);
    check({name, " MANCHE"},  8'(MANCHE),  8'(m));
    check({name, " PARTITA"}, 8'(PARTITA), 8'(pa));
    check({name, " COUNT"},   8'(COUNT),   8'(c));
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic drive_vec(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    INIZIO  = v.inizio;
    PRIMO   = v.primo;
    SECONDO = v.secondo;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard empty at %s[%0d]", v.tag, idx);
    end else begin
      e = sb_q.pop_front();
      check_outputs($sformatf("%s[%0d]", e.tag, idx), int'(e.manche), int'(e.partita), int'(e.count));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    INIZIO  = 1'b0;
    PRIMO   = 2'b00;
    SECONDO = 2'b00;
    #2;
    check_outputs("reset", RN, RN, 0);
    #11 rst = 1'b0;

    // Idle after reset: play attempts without INIZIO do nothing.
    table_q.push_back(mk("idle", 0, CA, SA, RN, RN, 0));

    // P1 sweep, MAX=4, lead reached at COUNT=4.
    table_q.push_back(mk("p1sweep", 1, NO, NO, RN, RN, 0));
    table_q.push_back(mk("p1sweep", 0, CA, SA, R1, RN, 1));
    table_q.push_back(mk("p1sweep", 0, SA, FO, R1, RN, 2));
    table_q.push_back(mk("p1sweep", 0, FO, CA, R1, RN, 3));
    table_q.push_back(mk("p1sweep", 0, CA, SA, R1, R1, 4));
    table_q.push_back(mk("p1sweep", 0, CA, SA, RN, RN, 4));

    // All ties, MAX=5, draw at the limit.
    table_q.push_back(mk("ties", 1, NO, SA, RN, RN, 0));
    for (int i = 1; i <= 4; i++) table_q.push_back(mk("ties", 0, SA, SA, RT, RN, i));
    table_q.push_back(mk("ties", 0, SA, SA, RT, RT, 5));
    table_q.push_back(mk("ties", 0, SA, SA, RN, RN, 5));

    // Invalid and repeat rules; ends at MAX=4 with D=+1.
    table_q.push_back(mk("rules", 1, NO, NO, RN, RN, 0));
    table_q.push_back(mk("rules", 0, CA, SA, R1, RN, 1));
    table_q.push_back(mk("rules", 0, CA, FO, RN, RN, 1));
    table_q.push_back(mk("rules", 0, NO, SA, RN, RN, 1));
    table_q.push_back(mk("rules", 0, SA, FO, R1, RN, 2));
    table_q.push_back(mk("rules", 0, FO, SA, R2, RN, 3));
    table_q.push_back(mk("rules", 0, CA, SA, RN, RN, 3));
    table_q.push_back(mk("rules", 0, FO, FO, RT, R1, 4));

    // Early lead of P2 is not enough before MIN_MANCHE.
    table_q.push_back(mk("early", 1, NO, NO, RN, RN, 0));
    table_q.push_back(mk("early", 0, SA, CA, R2, RN, 1));
    table_q.push_back(mk("early", 0, CA, FO, R2, RN, 2));
    table_q.push_back(mk("early", 0, SA, SA, RT, RN, 3));
    table_q.push_back(mk("early", 0, CA, FO, R2, R2, 4));

    // Restart mid-match with MAX=19; INIZIO beats a tie pair in the same cycle.
    table_q.push_back(mk("restart", 1, NO, NO, RN, RN, 0));
    table_q.push_back(mk("restart", 0, CA, SA, R1, RN, 1));
    table_q.push_back(mk("restart", 0, FO, SA, R2, RN, 2));
    table_q.push_back(mk("restart", 1, FO, FO, RN, RN, 0));
    for (int i = 1; i <= 18; i++) table_q.push_back(mk("restart", 0, SA, SA, RT, RN, i));
    table_q.push_back(mk("restart", 0, SA, SA, RT, RT, 19));
    table_q.push_back(mk("restart", 0, SA, SA, RN, RN, 19));

    foreach (table_q[i]) drive_vec(table_q[i], i);

    // Asynchronous reset mid-match at COUNT=3.
    drive_vec(mk("areset", 1, NO, NO, RN, RN, 0), 0);
    drive_vec(mk("areset", 0, CA, SA, R1, RN, 1), 1);
    drive_vec(mk("areset", 0, FO, SA, R2, RN, 2), 2);
    drive_vec(mk("areset", 0, CA, CA, RT, RN, 3), 3);
    #2 rst = 1'b1;
    #1;
    check_outputs("areset no-edge", RN, RN, 0);
    @(negedge clk);
    INIZIO  = 1'b1;
    PRIMO   = 2'b11;
    SECONDO = 2'b11;
    @(posedge clk);
    #1;
    check_outputs("areset held", RN, RN, 0);
    #2 rst = 1'b0;
    drive_vec(mk("areset after", 0, CA, SA, RN, RN, 0), 0);
    drive_vec(mk("areset after", 0, SA, FO, RN, RN, 0), 1);
    drive_vec(mk("areset after", 1, NO, NO, RN, RN, 0), 2);
    drive_vec(mk("areset after", 0, CA, SA, R1, RN, 1), 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
